cpu_run_ctrl: RTL and testbench

Parametrised run sequencer between the bench/top-level `enable`/`finish` pins and one or more CPU cores. It holds cores in reset for a programmable number of cycles, then releases them and gates their run enables. It counts execution cycles and latches per-core halt. It raises `finish` when every selected core has halted, or `timeout` when a watchdog expires. It generalises the single-core enable→finish handshake to N cores with masking, reset stretching, cycle accounting and abort.

---
 rtl/cpu_run_ctrl.sv | 144 ++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run sequencer for NUM_CORES cores.
// Holds the cores in reset for RESET_HOLD cycles, then releases them and
// gates their run enables. It counts RUN cycles, latches per-core halts and
// ends the run with finish (all selected cores halted), timeout (watchdog)
// or an abort (enable low).
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   enable       - level run request; low aborts or acknowledges
//   core_mask    - cores taking part, captured when a run starts
//   core_halt    - per-core halt indication
//   core_rst_n   - per-core active-low reset
//   core_run     - per-core run enable
//   halted       - sticky per-core halt flags for the current run
//   cycle_count  - RUN cycles in the current/last run (saturating)
//   busy         - high in HOLD or RUN
//   finish       - run completed normally
//   timeout      - run ended by the watchdog
module cpu_run_ctrl #(
  parameter int unsigned NUM_CORES  = 2,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned RESET_HOLD = 4,
  parameter int unsigned TIMEOUT    = 100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NUM_CORES-1:0] core_mask,
  input  logic [NUM_CORES-1:0] core_halt,
  output logic [NUM_CORES-1:0] core_rst_n,
  output logic [NUM_CORES-1:0] core_run,
  output logic [NUM_CORES-1:0] halted,
  output logic [CNT_W-1:0]     cycle_count,
  output logic                 busy,
  output logic                 finish,
  output logic                 timeout
);

  localparam int unsigned HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  // Value of cycle_count during the last permitted RUN cycle.
  localparam logic [CNT_W-1:0]  TMO_LAST  = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic              WDOG_EN   = (TIMEOUT != 0);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HOLD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_TMO  = 3'd4;

  logic [2:0]           state, state_d;
  logic [NUM_CORES-1:0] mask, mask_d;
  logic [NUM_CORES-1:0] halted_d, halt_seen;
  logic [HOLD_W-1:0]    hold_cnt, hold_d;
  logic [CNT_W-1:0]     cycle_d;
  logic [NUM_CORES-1:0] core_rst_n_d, core_run_d;
  logic                 busy_d, finish_d, timeout_d;

  // Next state and next register values; outputs derive from the next state
  // so every output is registered yet tracks the state it belongs to.
  always_comb begin
    state_d   = state;
    mask_d    = mask;
    halted_d  = halted;
    hold_d    = hold_cnt;
    cycle_d   = cycle_count;
    halt_seen = halted | (core_halt & mask);

    case (state)
      S_IDLE: begin
        if (enable) begin
          state_d  = S_HOLD;
          mask_d   = core_mask;
          halted_d = '0;
          cycle_d  = '0;
          hold_d   = HOLD_LOAD;
        end
      end
      S_HOLD: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (hold_cnt == '0) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_cnt - HOLD_W'(1);
        end
      end
      S_RUN: begin
        // Every RUN cycle counts, including the one that exits.
        halted_d = halt_seen;
        cycle_d  = (cycle_count == CNT_MAX) ? cycle_count : cycle_count + CNT_W'(1);
        if (!enable) begin
          state_d = S_IDLE;
        end else if ((halt_seen & mask) == mask) begin
          state_d = S_DONE;
        end else if (WDOG_EN && (cycle_count == TMO_LAST)) begin
          state_d = S_TMO;
        end
      end
      S_DONE, S_TMO: begin
        if (!enable) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    core_rst_n_d = ((state_d == S_RUN) || (state_d == S_DONE)) ? '1 : '0;
    core_run_d   = (state_d == S_RUN) ? (mask_d & ~halted_d) : '0;
    busy_d       = (state_d == S_HOLD) || (state_d == S_RUN);
    finish_d     = (state_d == S_DONE);
    timeout_d    = (state_d == S_TMO);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      mask        <= '0;
      hold_cnt    <= '0;
      halted      <= '0;
      cycle_count <= '0;
      core_rst_n  <= '0;
      core_run    <= '0;
      busy        <= 1'b0;
      finish      <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_d;
      mask        <= mask_d;
      hold_cnt    <= hold_d;
      halted      <= halted_d;
      cycle_count <= cycle_d;
      core_rst_n  <= core_rst_n_d;
      core_run    <= core_run_d;
      busy        <= busy_d;
      finish      <= finish_d;
      timeout     <= timeout_d;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl: vector table plus directed multi-cycle sequences.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  mask, halt;
  logic [1:0]  core_rst_n, core_run, halted;
  logic [31:0] cycle_count;
  logic        busy, finish, timeout;

  logic        en_s;
  logic [1:0]  mask_s, halt_s;
  logic [1:0]  core_rst_n_s, core_run_s, halted_s;
  logic [3:0]  cycle_count_s;
  logic        busy_s, finish_s, timeout_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.NUM_CORES(2), .CNT_W(32), .RESET_HOLD(4), .TIMEOUT(50)) dut (
    .clk(clk), .rst_n(rst_n), .enable(en), .core_mask(mask), .core_halt(halt),
    .core_rst_n(core_rst_n), .core_run(core_run), .halted(halted),
    .cycle_count(cycle_count), .busy(busy), .finish(finish), .timeout(timeout)
  );

  cpu_run_ctrl #(.NUM_CORES(2), .CNT_W(4), .RESET_HOLD(2), .TIMEOUT(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .enable(en_s), .core_mask(mask_s), .core_halt(halt_s),
    .core_rst_n(core_rst_n_s), .core_run(core_run_s), .halted(halted_s),
    .cycle_count(cycle_count_s), .busy(busy_s), .finish(finish_s), .timeout(timeout_s)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic [1:0]  mask;
    logic [1:0]  halt;
    logic [1:0]  e_rstn;
    logic [1:0]  e_run;
    logic [1:0]  e_halted;
    logic        e_busy;
    logic        e_fin;
    logic        e_tmo;
    logic [31:0] e_cc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic e, input logic [1:0] m, input logic [1:0] h,
                     input logic [1:0] ern, input logic [1:0] eru, input logic [1:0] eh,
                     input logic eb, input logic ef, input logic et, input logic [31:0] ec);
    vec_t v;
    v.rst = r; v.en = e; v.mask = m; v.halt = h;
    v.e_rstn = ern; v.e_run = eru; v.e_halted = eh;
    v.e_busy = eb; v.e_fin = ef; v.e_tmo = et; v.e_cc = ec;
    vq.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Raise enable and step through the reset-hold phase into the first RUN cycle.
  task automatic start_main(input logic [1:0] m);
    en = 1'b1; mask = m; halt = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("hold%0d core_rst_n", i), 32'(core_rst_n), 32'd0);
      chk($sformatf("hold%0d busy", i), 32'(busy), 32'd1);
    end
    tick();
    chk("run1 core_rst_n", 32'(core_rst_n), 32'd3);
    chk("run1 core_run", 32'(core_run), 32'(m));
    chk("run1 cycle_count", cycle_count, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL time_limit: simulation did not end, got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; mask = 2'b11; halt = 2'b00;
    en_s = 1'b0; mask_s = 2'b00; halt_s = 2'b00;

    //  rst en  mask   halt   rstn   run    halted busy fin  tmo  cc
    add(0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    add(0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    add(0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    // release with enable high, empty mask
    add(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0);
    add(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0);
    add(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0);
    add(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0);
    add(1, 1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1, 0, 0, 0);
    add(1, 1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 0, 1, 0, 1);
    add(1, 1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 0, 1, 0, 1);
    add(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1);
    // abort during HOLD cycle 2
    add(1, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0);
    add(1, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0);
    add(1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    // masked run: core1 toggles halt and mask input changes mid-run
    add(1, 1, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0);
    add(1, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0);
    add(1, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0);
    add(1, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0);
    add(1, 1, 2'b11, 2'b00, 2'b11, 2'b01, 2'b00, 1, 0, 0, 0);
    add(1, 1, 2'b11, 2'b10, 2'b11, 2'b01, 2'b00, 1, 0, 0, 1);
    add(1, 1, 2'b11, 2'b00, 2'b11, 2'b01, 2'b00, 1, 0, 0, 2);
    add(1, 1, 2'b11, 2'b10, 2'b11, 2'b01, 2'b00, 1, 0, 0, 3);
    add(1, 1, 2'b11, 2'b00, 2'b11, 2'b01, 2'b00, 1, 0, 0, 4);
    add(1, 1, 2'b11, 2'b10, 2'b11, 2'b01, 2'b00, 1, 0, 0, 5);
    add(1, 1, 2'b11, 2'b10, 2'b11, 2'b01, 2'b00, 1, 0, 0, 6);
    add(1, 1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b01, 0, 1, 0, 7);
    add(1, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0, 7);

    foreach (vq[i]) begin
      rst_n = vq[i].rst; en = vq[i].en; mask = vq[i].mask; halt = vq[i].halt;
      tick();
      chk($sformatf("v%0d core_rst_n", i), 32'(core_rst_n), 32'(vq[i].e_rstn));
      chk($sformatf("v%0d core_run", i), 32'(core_run), 32'(vq[i].e_run));
      chk($sformatf("v%0d halted", i), 32'(halted), 32'(vq[i].e_halted));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vq[i].e_busy));
      chk($sformatf("v%0d finish", i), 32'(finish), 32'(vq[i].e_fin));
      chk($sformatf("v%0d timeout", i), 32'(timeout), 32'(vq[i].e_tmo));
      chk($sformatf("v%0d cycle_count", i), cycle_count, vq[i].e_cc);
    end

    // Normal two-core run: core0 halts in cycle 10, core1 in cycle 25.
    start_main(2'b11);
    for (int k = 1; k <= 25; k++) begin
      halt = (k == 10) ? 2'b01 : (k == 25) ? 2'b10 : 2'b00;
      tick();
      chk($sformatf("norm%0d cycle_count", k), cycle_count, 32'(k));
      if (k < 25) begin
        chk($sformatf("norm%0d core_run", k), 32'(core_run), (k >= 10) ? 32'd2 : 32'd3);
        chk($sformatf("norm%0d halted", k), 32'(halted), (k >= 10) ? 32'd1 : 32'd0);
        chk($sformatf("norm%0d finish", k), 32'(finish), 32'd0);
      end
    end
    chk("norm finish", 32'(finish), 32'd1);
    chk("norm busy", 32'(busy), 32'd0);
    chk("norm halted", 32'(halted), 32'd3);
    chk("norm core_run", 32'(core_run), 32'd0);
    chk("norm core_rst_n", 32'(core_rst_n), 32'd3);
    halt = 2'b00; en = 1'b0;
    tick();
    chk("norm ack finish", 32'(finish), 32'd0);
    chk("norm ack core_rst_n", 32'(core_rst_n), 32'd0);

    // Watchdog expiry after 50 RUN cycles without halts.
    start_main(2'b11);
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (k < 50) chk($sformatf("wd%0d timeout", k), 32'(timeout), 32'd0);
    end
    chk("wd timeout", 32'(timeout), 32'd1);
    chk("wd cycle_count", cycle_count, 32'd50);
    chk("wd core_rst_n", 32'(core_rst_n), 32'd0);
    chk("wd core_run", 32'(core_run), 32'd0);
    chk("wd finish", 32'(finish), 32'd0);
    chk("wd busy", 32'(busy), 32'd0);
    tick();
    chk("wd hold timeout", 32'(timeout), 32'd1);
    en = 1'b0;
    tick();
    chk("wd ack timeout", 32'(timeout), 32'd0);
    chk("wd ack cycle_count", cycle_count, 32'd50);

    // Final halt coinciding with the watchdog cycle wins.
    start_main(2'b01);
    for (int k = 1; k <= 50; k++) begin
      halt = (k == 50) ? 2'b01 : 2'b00;
      tick();
    end
    chk("wdh finish", 32'(finish), 32'd1);
    chk("wdh timeout", 32'(timeout), 32'd0);
    chk("wdh cycle_count", cycle_count, 32'd50);
    halt = 2'b00; en = 1'b0;
    tick();

    // Abort in RUN cycle 12, then restart.
    start_main(2'b11);
    for (int k = 1; k <= 12; k++) begin
      en = (k == 12) ? 1'b0 : 1'b1;
      tick();
    end
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort core_rst_n", 32'(core_rst_n), 32'd0);
    chk("abort cycle_count", cycle_count, 32'd12);
    chk("abort finish", 32'(finish), 32'd0);
    chk("abort timeout", 32'(timeout), 32'd0);
    en = 1'b1;
    tick();
    chk("restart busy", 32'(busy), 32'd1);
    chk("restart cycle_count", cycle_count, 32'd0);
    en = 1'b0;
    tick();

    // Reset in the middle of a run.
    start_main(2'b11);
    for (int k = 1; k <= 3; k++) begin
      halt = (k == 2) ? 2'b01 : 2'b00;
      tick();
    end
    chk("mid halted", 32'(halted), 32'd1);
    rst_n = 1'b0; halt = 2'b00;
    tick();
    chk("rst core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rst core_run", 32'(core_run), 32'd0);
    chk("rst halted", 32'(halted), 32'd0);
    chk("rst cycle_count", cycle_count, 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    rst_n = 1'b1; en = 1'b0;
    tick();

    // Saturating 4-bit counter with watchdog disabled.
    en_s = 1'b1; mask_s = 2'b11; halt_s = 2'b00;
    repeat (3) tick();
    chk("sat start core_rst_n", 32'(core_rst_n_s), 32'd3);
    chk("sat start busy", 32'(busy_s), 32'd1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("sat%0d cycle_count", k), 32'(cycle_count_s), (k > 15) ? 32'd15 : 32'(k));
      chk($sformatf("sat%0d timeout", k), 32'(timeout_s), 32'd0);
    end
    chk("sat busy", 32'(busy_s), 32'd1);
    en_s = 1'b0;
    tick();
    chk("sat abort busy", 32'(busy_s), 32'd0);
    chk("sat abort cycle_count", 32'(cycle_count_s), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
